// File: rtl/bnn_pkg.sv
// Shared phase-bus encoding and sizing constants for the MNIST BNN pipeline.
// Every layer datapath decodes phase_t from this package.
package bnn_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_L1   = 3'd2,
      S_L2   = 3'd3,
      S_L3   = 3'd4,
      S_DONE = 3'd5,
      S_ERR  = 3'd7
   } phase_t;

   localparam int LOAD_BEATS_DEF = 98;
   localparam int PIX_W          = 28;
   localparam int CLASS_W        = 4;

   function automatic logic is_layer(phase_t p);
      return (p == S_L1) || (p == S_L2) || (p == S_L3);
   endfunction

endpackage

// File: rtl/bnn_watchdog.sv
// Layer-phase timeout counter; reloads on each layer entry and reports expiry
// once the counter has run down to zero while still enabled.
module bnn_watchdog #(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = CW'(TIMEOUT_CYCLES - 1);
      else if (enable && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign expired = enable && (cnt_q == '0);

endmodule

// File: rtl/bnn_layer_sequencer.sv
// Top-level BNN scheduler: image load, then layer1/layer2/output phases on the phase bus.
// Optional layer timeout watchdog enabled with `define BNN_WATCHDOG_EN.
module bnn_layer_sequencer
   import bnn_pkg::*;
#(
   parameter int LOAD_BEATS     = LOAD_BEATS_DEF,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int RESULT_HOLD    = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [6:0]         load_addr,
   output logic               load_we,
   input  logic               l1_done,
   input  logic               l2_done,
   input  logic               l3_done,
   input  logic [CLASS_W-1:0] l3_class,
   output phase_t             state,
   output logic               busy,
   output logic               result_valid,
   output logic [CLASS_W-1:0] result,
   output logic               error
);

   localparam logic [6:0] LAST_ADDR = 7'(LOAD_BEATS - 1);

   phase_t               state_q, state_d;
   logic [6:0]           load_addr_q, load_addr_d;
   logic [CLASS_W-1:0]   result_q, result_d;
   logic                 in_ready_q, busy_q, result_valid_q;
   logic                 wd_expired;

   always_comb begin
      state_d     = state_q;
      load_addr_d = load_addr_q;
      result_d    = result_q;
      case (state_q)
         S_IDLE: if (start) begin
            state_d     = S_LOAD;
            load_addr_d = '0;
         end
         S_LOAD: if (in_valid) begin
            if (load_addr_q == LAST_ADDR) begin
               load_addr_d = '0;
               state_d     = S_L1;
            end else begin
               load_addr_d = load_addr_q + 7'd1;
            end
         end
         // The current phase's done beats an expiry on the same cycle.
         S_L1: if (l1_done) state_d = S_L2;
               else if (wd_expired) state_d = S_ERR;
         S_L2: if (l2_done) state_d = S_L3;
               else if (wd_expired) state_d = S_ERR;
         S_L3: if (l3_done) begin
            state_d  = S_DONE;
            result_d = l3_class;
         end else if (wd_expired) begin
            state_d = S_ERR;
         end
         S_DONE: if (RESULT_HOLD == 0) begin
            state_d = S_IDLE;
         end else if (start) begin
            state_d     = S_LOAD;
            load_addr_d = '0;
         end
         S_ERR: if (start) begin
            state_d     = S_LOAD;
            load_addr_d = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         load_addr_q    <= '0;
         result_q       <= '0;
         in_ready_q     <= 1'b0;
         busy_q         <= 1'b0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         load_addr_q    <= load_addr_d;
         result_q       <= result_d;
         in_ready_q     <= (state_d == S_LOAD);
         busy_q         <= (state_d != S_IDLE) && (state_d != S_DONE);
         result_valid_q <= (state_d == S_DONE);
      end
   end

`ifdef BNN_WATCHDOG_EN
   logic error_q;

   bnn_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wd (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (is_layer(state_d) && (state_d != state_q)),
      .enable  (is_layer(state_q)),
      .expired (wd_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) error_q <= 1'b0;
      else        error_q <= (state_d == S_ERR);
   end

   assign error = error_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^32'(TIMEOUT_CYCLES);
   assign wd_expired     = 1'b0;
   assign error          = 1'b0;
`endif

   assign state        = state_q;
   assign load_addr    = load_addr_q;
   assign in_ready     = in_ready_q;
   assign busy         = busy_q;
   assign result_valid = result_valid_q;
   assign result       = result_q;
   assign load_we      = in_valid & in_ready_q;

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Directed bench for bnn_layer_sequencer: load, phase stepping, result capture, async reset,
// and (with BNN_WATCHDOG_EN) the layer timeout.
module tb_bnn_layer_sequencer;
   import bnn_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n, start, in_valid, l1_done, l2_done, l3_done;
   logic [3:0] l3_class;
   logic       in_ready, load_we, busy, result_valid, error;
   logic [6:0] load_addr;
   phase_t     state;
   logic [3:0] result;

   int checks = 0;
   int errors = 0;

   bnn_layer_sequencer #(
      .LOAD_BEATS     (98),
      .TIMEOUT_CYCLES (16),
      .RESULT_HOLD    (1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .load_addr    (load_addr),
      .load_we      (load_we),
      .l1_done      (l1_done),
      .l2_done      (l2_done),
      .l3_done      (l3_done),
      .l3_class     (l3_class),
      .state        (state),
      .busy         (busy),
      .result_valid (result_valid),
      .result       (result),
      .error        (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_image();
      in_valid = 1'b1;
      repeat (98) step();
      in_valid = 1'b0;
   endtask

   initial begin
      int n_we;
      int exp_addr;
      int cyc;

      rst_n = 1'b0; start = 0; in_valid = 0;
      l1_done = 0; l2_done = 0; l3_done = 0; l3_class = 4'd0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
      check("rst_state", state, S_IDLE);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_load_addr", load_addr, 0);
      check("rst_result", result, 0);
      check("rst_result_valid", result_valid, 0);
      check("rst_error", error, 0);

      // Dones in idle are ignored.
      l1_done = 1; l3_done = 1;
      step();
      check("idle_done_ignored", state, S_IDLE);
      l1_done = 0; l3_done = 0;

      // Start, then back-to-back load with start held high.
      start = 1;
      step();
      check("start_to_load", state, S_LOAD);
      check("load_in_ready", in_ready, 1);
      check("load_busy", busy, 1);
      check("load_addr0", load_addr, 0);
      for (int i = 0; i < 98; i++) begin
         in_valid = 1'b1;
         #1;
         if (load_addr !== 7'(i) || load_we !== 1'b1) check("b2b_beat", {load_we, load_addr}, {1'b1, 7'(i)});
         if (i == 97) check("b2b_last_state", state, S_LOAD);
         step();
      end
      in_valid = 0;
      check("b2b_state_l1", state, S_L1);
      check("b2b_addr_wrap", load_addr, 0);
      check("l1_in_ready", in_ready, 0);
      check("l1_load_we", load_we, 0);

      // Foreign dones in S_L1 are ignored; start still held high.
      l2_done = 1; step(); l2_done = 0;
      check("l1_ign_l2done", state, S_L1);
      l3_done = 1; l3_class = 4'd3; step(); l3_done = 0;
      check("l1_ign_l3done", state, S_L1);
      l1_done = 1; step(); l1_done = 0;
      check("l1_to_l2", state, S_L2);
      l1_done = 1; step(); l1_done = 0;
      check("l2_ign_l1done", state, S_L2);
      l2_done = 1; step(); l2_done = 0;
      check("l2_to_l3", state, S_L3);
      check("l3_busy", busy, 1);
      l3_class = 4'd7; l3_done = 1; start = 0;
      step();
      l3_done = 0; l3_class = 4'd0;
      check("l3_to_done", state, S_DONE);
      check("done_result", result, 7);
      check("done_result_valid", result_valid, 1);
      check("done_busy", busy, 0);
      step();
      check("done_hold_state", state, S_DONE);
      check("done_hold_valid", result_valid, 1);

      // Start in S_DONE restarts directly into S_LOAD.
      start = 1; step(); start = 0;
      check("done_start_load", state, S_LOAD);
      check("done_start_rv", result_valid, 0);
      check("done_start_result", result, 7);

      // Stalling load: irregular valid pattern.
      n_we = 0; exp_addr = 0; cyc = 0;
      while (state == S_LOAD && cyc < 400) begin
         in_valid = ((cyc % 3) != 1) && ((cyc % 7) != 0);
         #1;
         if (load_we !== in_valid) check("stall_we", load_we, in_valid);
         if (in_valid) begin
            if (load_addr !== 7'(exp_addr)) check("stall_addr", load_addr, exp_addr);
            exp_addr++;
         end
         n_we += int'(load_we);
         step();
         cyc++;
      end
      in_valid = 0;
      check("stall_we_count", n_we, 98);
      check("stall_state_l1", state, S_L1);

      // Async reset mid S_L2, no clock edge needed.
      l1_done = 1; step(); l1_done = 0;
      check("pre_rst_l2", state, S_L2);
      @(negedge clk);
      rst_n = 0;
      #1;
      check("async_rst_state", state, S_IDLE);
      check("async_rst_busy", busy, 0);
      check("async_rst_addr", load_addr, 0);
      check("async_rst_result", result, 0);
      #2 rst_n = 1;
      step();

      // Async reset mid load clears a non-zero address.
      start = 1; step(); start = 0;
      in_valid = 1; repeat (5) step(); in_valid = 0;
      check("mid_load_addr", load_addr, 5);
      @(negedge clk);
      rst_n = 0;
      #1;
      check("mid_load_rst_addr", load_addr, 0);
      check("mid_load_rst_ready", in_ready, 0);
      #2 rst_n = 1;
      step();

      // Dones held as levels: one cycle per phase, class > 9 captured as-is.
      start = 1; step(); start = 0;
      l1_done = 1; l2_done = 1; l3_done = 1; l3_class = 4'd12;
      load_image();
      check("lvl_l1", state, S_L1);
      step(); check("lvl_l2", state, S_L2);
      step(); check("lvl_l3", state, S_L3);
      step(); check("lvl_done", state, S_DONE);
      check("lvl_result12", result, 12);
      l1_done = 0; l2_done = 0; l3_done = 0;

`ifdef BNN_WATCHDOG_EN
      // Timeout after 16 cycles in S_L1 without done.
      start = 1; step(); start = 0;
      load_image();
      check("wd_l1_entry", state, S_L1);
      repeat (15) step();
      check("wd_cycle16_l1", state, S_L1);
      check("wd_cycle16_err0", error, 0);
      step();
      check("wd_err_state", state, S_ERR);
      check("wd_error", error, 1);
      check("wd_err_busy", busy, 1);
      step();
      check("wd_err_hold", state, S_ERR);
      start = 1; step(); start = 0;
      check("wd_err_restart", state, S_LOAD);
      check("wd_err_clear", error, 0);
      // Done on the expiry cycle wins.
      load_image();
      repeat (15) step();
      l1_done = 1; step(); l1_done = 0;
      check("wd_done_wins", state, S_L2);
      check("wd_done_wins_err", error, 0);
`else
      check("no_wd_error", error, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL timeout: simulation did not complete, observed running expected finished");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "time limit");
   end

endmodule
